dpram_arb: RTL and testbench

DPRAM_ARB -- requirements
Module: dpram_arb

---
 rtl/dpram_arb_pkg.sv | 27 ++
 rtl/dpram_arb_if.sv | 47 ++++
 rtl/dpram_arb_rr_pick.sv | 32 +++
 rtl/dpram_arb.sv | 162 ++++++++++++++++
 tb/tb_dpram_arb.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/dpram_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : dpram_arb_pkg
//  Purpose : Shared constants for the DPRAM ownership arbiter: FSM state
//            encodings, the supported requester upper bound and an
//            index-width helper.
//  Revision: 1.0 - initial release
// ============================================================================
package dpram_arb_pkg;

    // Largest requester count the arbiter is built for
    localparam int c_N_REQ_MAX = 8;

    // FSM state encodings
    localparam int c_STATE_W = 2;
    localparam logic [c_STATE_W-1:0] S_IDLE      = 2'd0;
    localparam logic [c_STATE_W-1:0] S_GRANT     = 2'd1;
    localparam logic [c_STATE_W-1:0] S_WAIT_BUSY = 2'd2;
    localparam logic [c_STATE_W-1:0] S_WAIT_DONE = 2'd3;

    // Bits needed to hold a requester index (never less than one)
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dpram_arb_if.sv
`default_nettype none
// ============================================================================
//  Module  : dpram_arb_if
//  Purpose : Bundle of requester-side and DPRAM-side signals of the arbiter.
//            master = requesters plus downstream DPRAM environment,
//            slave  = the arbiter itself.
//  Revision: 1.0 - initial release
// ============================================================================
interface dpram_arb_if #(
    parameter int N_REQ             = 4,
    parameter int P_DPRAM_ADR_WIDTH = 10
);
    // Requester side
    logic [N_REQ-1:0]                   req;
    logic [N_REQ-1:0]                   gnt;
    logic [N_REQ-1:0]                   req_wren;
    logic [N_REQ*P_DPRAM_ADR_WIDTH-1:0] req_addr;
    logic [N_REQ*32-1:0]                req_data;
    logic [N_REQ*16-1:0]                req_len;
    logic [N_REQ-1:0]                   req_run;
    logic [N_REQ-1:0]                   req_busy;

    // DPRAM side
    logic                               dpram_wren;
    logic [P_DPRAM_ADR_WIDTH-1:0]       dpram_addr;
    logic [31:0]                        dpram_data;
    logic [15:0]                        dpram_len;
    logic                               dpram_run;
    logic                               dpram_busy;

    // Status
    logic                               tmo_err;
    logic [15:0]                        tmo_cnt;

    modport master (
        output req, req_wren, req_addr, req_data, req_len, req_run, dpram_busy,
        input  gnt, req_busy, dpram_wren, dpram_addr, dpram_data, dpram_len,
               dpram_run, tmo_err, tmo_cnt
    );

    modport slave (
        input  req, req_wren, req_addr, req_data, req_len, req_run, dpram_busy,
        output gnt, req_busy, dpram_wren, dpram_addr, dpram_data, dpram_len,
               dpram_run, tmo_err, tmo_cnt
    );
endinterface
`default_nettype wire

// File: rtl/dpram_arb_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module  : rr_pick
//  Purpose : Round-robin picker. Returns the first set request bit at or
//            after the pointer, wrapping modulo N.
//  Revision: 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  wire logic [N-1:0]     i_req,
    input  wire logic [IDX_W-1:0] i_ptr,
    output logic                  o_valid,
    output logic [IDX_W-1:0]      o_idx
);

    // Scan offsets from farthest to nearest so the nearest hit wins last
    always_comb begin
        o_valid = |i_req;
        o_idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            int j;
            j = (int'(i_ptr) + k) % N;
            if (i_req[j]) begin
                o_idx = IDX_W'(j);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/dpram_arb.sv
`default_nettype none
// ============================================================================
//  Module  : dpram_arb
//  Purpose : Round-robin arbiter handing a shared DPRAM to one of N_REQ
//            requesters, passing the buffer on to a downstream reader and
//            waiting for that reader to release it.
//  Revision: 1.0 - initial release
// ============================================================================
module dpram_arb
    import dpram_arb_pkg::*;
#(
    parameter int N_REQ             = 4,
    parameter int P_DPRAM_ADR_WIDTH = 10,
    parameter int P_BUSY_TMO        = 255
) (
    input  wire logic   clk,
    input  wire logic   rst,
    dpram_arb_if.slave  bus
);

    localparam int              c_IDX_W    = idx_width(N_REQ);
    localparam logic [15:0]     c_TMO_LAST = 16'(P_BUSY_TMO - 1);
    localparam logic [N_REQ-1:0] c_ONE     = N_REQ'(1);

    logic [c_STATE_W-1:0]         r_state, w_state_nxt;
    logic [N_REQ-1:0]             r_gnt;
    logic [c_IDX_W-1:0]           r_ptr;
    logic                         r_run;
    logic [15:0]                  r_len;
    logic                         r_tmo_err;
    logic [15:0]                  r_tmo_cnt;
    logic [15:0]                  r_tmo_tmr;

    logic                         w_pick_vld;
    logic [c_IDX_W-1:0]           w_pick_idx;
    logic                         w_issue, w_start, w_abort, w_tmo_hit, w_done;
    logic                         w_wren;
    logic [P_DPRAM_ADR_WIDTH-1:0] w_addr;
    logic [31:0]                  w_data;
    logic [15:0]                  w_sel_len;
    logic [N_REQ-1:0]             w_req_busy;

    rr_pick #(
        .N      (N_REQ),
        .IDX_W  (c_IDX_W)
    ) u_rr_pick (
        .i_req   (bus.req),
        .i_ptr   (r_ptr),
        .o_valid (w_pick_vld),
        .o_idx   (w_pick_idx)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state logic and one-cycle transition events
    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_start     = 1'b0;
        w_abort     = 1'b0;
        w_tmo_hit   = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_pick_vld && !bus.dpram_busy) begin
                    w_issue     = 1'b1;
                    w_state_nxt = S_GRANT;
                end
            end
            S_GRANT: begin
                // A run from the owner takes priority over its req dropping
                if (|(bus.req_run & r_gnt)) begin
                    w_start     = 1'b1;
                    w_state_nxt = S_WAIT_BUSY;
                end else if (~|(bus.req & r_gnt)) begin
                    w_abort     = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_WAIT_BUSY: begin
                if (bus.dpram_busy) begin
                    w_state_nxt = S_WAIT_DONE;
                end else if (r_tmo_tmr == c_TMO_LAST) begin
                    w_tmo_hit   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_WAIT_DONE: begin
                if (!bus.dpram_busy) begin
                    w_done      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output selection: route the owner's write port and length, busy view
    always_comb begin
        w_wren     = 1'b0;
        w_addr     = '0;
        w_data     = '0;
        w_sel_len  = '0;
        w_req_busy = '1;
        for (int i = 0; i < N_REQ; i++) begin
            if (r_gnt[i]) begin
                w_wren    = bus.req_wren[i];
                w_addr    = bus.req_addr[i*P_DPRAM_ADR_WIDTH +: P_DPRAM_ADR_WIDTH];
                w_data    = bus.req_data[i*32 +: 32];
                w_sel_len = bus.req_len[i*16 +: 16];
            end
            w_req_busy[i] = !(r_gnt[i] && (r_state == S_GRANT));
        end
    end

    // Grant, pointer, handoff and timeout bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            r_gnt     <= '0;
            r_ptr     <= '0;
            r_run     <= 1'b0;
            r_len     <= '0;
            r_tmo_err <= 1'b0;
            r_tmo_cnt <= '0;
            r_tmo_tmr <= '0;
        end else begin
            r_run     <= w_start;
            r_tmo_err <= w_tmo_hit;
            if (w_issue) begin
                r_gnt <= c_ONE << w_pick_idx;
                r_ptr <= (w_pick_idx == c_IDX_W'(N_REQ - 1)) ? '0 : w_pick_idx + 1'b1;
            end else if (w_abort || w_tmo_hit || w_done) begin
                r_gnt <= '0;
            end
            if (w_start) begin
                r_len     <= w_sel_len;
                r_tmo_tmr <= '0;
            end else if (r_state == S_WAIT_BUSY) begin
                r_tmo_tmr <= r_tmo_tmr + 16'd1;
            end
            if (w_tmo_hit && (r_tmo_cnt != 16'hFFFF)) begin
                r_tmo_cnt <= r_tmo_cnt + 16'd1;
            end
        end
    end

    assign bus.gnt        = r_gnt;
    assign bus.req_busy   = w_req_busy;
    assign bus.dpram_wren = w_wren;
    assign bus.dpram_addr = w_addr;
    assign bus.dpram_data = w_data;
    assign bus.dpram_len  = r_len;
    assign bus.dpram_run  = r_run;
    assign bus.tmo_err    = r_tmo_err;
    assign bus.tmo_cnt    = r_tmo_cnt;

endmodule
`default_nettype wire

// File: tb/tb_dpram_arb.sv
`default_nettype none
// ============================================================================
//  Module  : tb_dpram_arb
//  Purpose : Directed self-checking bench for dpram_arb (4 requesters,
//            busy timeout of 8 cycles).
//  Revision: 1.0 - initial release
// ============================================================================
module tb_dpram_arb;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_pass = 0;
    int   n_runs = 0;

    logic [3:0] order [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [3:0] cur;

    dpram_arb_if #(.N_REQ(4), .P_DPRAM_ADR_WIDTH(10)) bus ();

    dpram_arb #(
        .N_REQ             (4),
        .P_DPRAM_ADR_WIDTH (10),
        .P_BUSY_TMO        (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Count handoff pulses away from the active edge
    always @(negedge clk) begin
        if (bus.dpram_run) n_runs++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Owner hands off, reader takes the buffer for one cycle, then next grant
    task automatic serve(input logic [3:0] g);
        bus.req_run    = g;
        tick();
        bus.req_run    = '0;
        bus.dpram_busy = 1'b1;
        tick();
        bus.dpram_busy = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.req        = '0;
        bus.req_wren   = '0;
        bus.req_addr   = '0;
        bus.req_data   = '0;
        bus.req_len    = '0;
        bus.req_run    = '0;
        bus.dpram_busy = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        chk("rst_gnt",      32'(bus.gnt),        32'h0);
        chk("rst_run",      32'(bus.dpram_run),  32'h0);
        chk("rst_len",      32'(bus.dpram_len),  32'h0);
        chk("rst_tmo_err",  32'(bus.tmo_err),    32'h0);
        chk("rst_tmo_cnt",  32'(bus.tmo_cnt),    32'h0);
        chk("rst_req_busy", 32'(bus.req_busy),   32'hF);
        chk("rst_wren",     32'(bus.dpram_wren), 32'h0);

        // Single requester: grant, three writes, run, busy for 5 cycles
        bus.req = 4'b0001;
        tick();
        chk("t1_gnt",      32'(bus.gnt),      32'h1);
        chk("t1_req_busy", 32'(bus.req_busy), 32'hE);
        for (int k = 0; k < 3; k++) begin
            bus.req_wren       = 4'b0001;
            bus.req_addr[9:0]  = 10'(16 + k);
            bus.req_data[31:0] = 32'(160 + k);
            #1;
            chk("t1_wren", 32'(bus.dpram_wren), 32'h1);
            chk("t1_addr", 32'(bus.dpram_addr), 32'(16 + k));
            chk("t1_data", bus.dpram_data,      32'(160 + k));
            tick();
        end
        bus.req_wren      = '0;
        bus.req_run       = 4'b0001;
        bus.req_len[15:0] = 16'h0010;
        tick();
        chk("t1_run",      32'(bus.dpram_run), 32'h1);
        chk("t1_len",      32'(bus.dpram_len), 32'h0010);
        chk("t1_busy_all", 32'(bus.req_busy),  32'hF);
        bus.req_run    = '0;
        bus.dpram_busy = 1'b1;
        tick();
        chk("t1_run_pulse", 32'(bus.dpram_run), 32'h0);
        repeat (4) tick();
        bus.dpram_busy = 1'b0;
        bus.req        = '0;
        tick();
        chk("t1_gnt_clr", 32'(bus.gnt), 32'h0);
        chk("t1_n_runs",  32'(n_runs),  32'h1);

        // All four pending: round-robin order 0,1,2,3,0
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.req = 4'b1111;
        tick();
        chk("t2_gnt0", 32'(bus.gnt), 32'h1);
        cur = 4'b0001;
        for (int k = 0; k < 4; k++) begin
            serve(cur);
            cur = order[k];
            chk("t2_gnt_rr", 32'(bus.gnt), 32'(cur));
        end

        // Granted req 2 drops without run; next grant goes to 3
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.req = 4'b0100;
        tick();
        chk("t3_gnt2", 32'(bus.gnt), 32'h4);
        bus.req = 4'b1011;
        tick();
        chk("t3_gnt_clr", 32'(bus.gnt),       32'h0);
        chk("t3_no_run",  32'(bus.dpram_run), 32'h0);
        tick();
        chk("t3_gnt3", 32'(bus.gnt), 32'h8);

        // Run from an ungranted requester is ignored
        bus.req_run = 4'b0001;
        tick();
        bus.req_run = '0;
        chk("t4_no_run",   32'(bus.dpram_run), 32'h0);
        chk("t4_req_busy", 32'(bus.req_busy),  32'h7);

        // Requester 1 writes while requester 0 owns the DPRAM
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.req = 4'b0011;
        tick();
        chk("t5_gnt0", 32'(bus.gnt), 32'h1);
        bus.req_wren        = 4'b0010;
        bus.req_addr[19:10] = 10'h3FF;
        bus.req_data[63:32] = 32'hDEADBEEF;
        #1;
        chk("t5_wren_other", 32'(bus.dpram_wren), 32'h0);
        bus.req_wren       = 4'b0011;
        bus.req_addr[9:0]  = 10'h005;
        bus.req_data[31:0] = 32'h0000_1234;
        #1;
        chk("t5_wren_own", 32'(bus.dpram_wren), 32'h1);
        chk("t5_addr_own", 32'(bus.dpram_addr), 32'h005);
        chk("t5_data_own", bus.dpram_data,      32'h0000_1234);

        // Busy never rises: timeout 8 cycles after the handoff pulse
        bus.req_wren      = '0;
        bus.req_run       = 4'b0001;
        bus.req_len[15:0] = 16'h0042;
        tick();
        chk("t6_run", 32'(bus.dpram_run), 32'h1);
        chk("t6_len", 32'(bus.dpram_len), 32'h0042);
        bus.req_run = '0;
        repeat (7) tick();
        chk("t6_tmo_early", 32'(bus.tmo_err), 32'h0);
        tick();
        chk("t6_tmo_err", 32'(bus.tmo_err), 32'h1);
        chk("t6_tmo_cnt", 32'(bus.tmo_cnt), 32'h1);
        chk("t6_gnt_clr", 32'(bus.gnt),     32'h0);
        tick();
        chk("t6_tmo_pulse", 32'(bus.tmo_err), 32'h0);
        chk("t6_gnt1",      32'(bus.gnt),     32'h2);

        // Reset while the reader holds the buffer
        bus.req_run = 4'b0010;
        tick();
        bus.req_run    = '0;
        bus.dpram_busy = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("t7_gnt",     32'(bus.gnt),       32'h0);
        chk("t7_tmo_cnt", 32'(bus.tmo_cnt),   32'h0);
        chk("t7_run",     32'(bus.dpram_run), 32'h0);
        rst            = 1'b0;
        bus.dpram_busy = 1'b0;
        bus.req        = 4'b1111;
        tick();
        chk("t7_ptr0",    32'(bus.gnt), 32'h1);
        chk("all_n_runs", 32'(n_runs),  32'h7);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
